// File: rtl/writeback_l2.sv
// -----------------------------------------------------------------------------
// writeback_l2
//   Layer-2 output writer. Takes one signed accumulator result per handshake,
//   rescales it (arithmetic right shift by SHIFT, then signed saturation to
//   DW_OUT bits) and writes it to the output feature-map RAM in raster order at
//   base_addr + y*wt_out + x. Pulses frame_done when the last write goes out.
//
// Optional feature macro: WRITEBACK_RELU_EN
//   When defined, negative saturated results are written as 0 (ReLU).
//   Latency and handshake are the same in both builds.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-low reset
//   start        one-cycle pulse, latches ht_out/wt_out/base_addr in IDLE
//   ht_out       output map height (9 bits)
//   wt_out       output map width (9 bits)
//   base_addr    first RAM address of the map
//   in_valid     result beat valid
//   in_data      signed result (DW_IN bits)
//   in_ready     writer can accept a beat (RUN only)
//   wr_en        RAM write strobe, one cycle per accepted beat
//   wr_addr      RAM write address (holds when wr_en=0)
//   wr_data      RAM write data (holds when wr_en=0)
//   busy         frame in progress (RUN or DONE)
//   frame_done   one-cycle pulse, coincident with the last wr_en
//   dbg_state_o  current FSM state (0=IDLE, 1=RUN, 2=DONE)
//
// Handshake: a beat transfers on a rising edge where in_valid && in_ready are
// both high. The upstream holds in_data stable while in_valid is high and
// in_ready is low; in_ready never depends on in_valid.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module writeback_l2 #(
  parameter int DW_IN  = 20,
  parameter int DW_OUT = 16,
  parameter int SHIFT  = 4,
  parameter int AW     = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [8:0]        ht_out,
  input  logic [8:0]        wt_out,
  input  logic [AW-1:0]     base_addr,
  input  logic              in_valid,
  input  logic [DW_IN-1:0]  in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [AW-1:0]     wr_addr,
  output logic [DW_OUT-1:0] wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Frame geometry latched at start
  logic [8:0]    ht_q, wt_q;
  logic [AW-1:0] base_q;

  // Raster position; row_base_q replaces y*wt (accumulated, wraps mod 2^AW)
  logic [8:0]    x_q, y_q;
  logic [AW-1:0] row_base_q;

  // Registered write port
  logic              wr_en_q;
  logic [AW-1:0]     wr_addr_q;
  logic [DW_OUT-1:0] wr_data_q;

  logic accept;
  logic x_last, y_last, last_beat;
  logic start_ok, zero_size;

  assign accept    = (state_q == ST_RUN) && in_valid;
  assign x_last    = (x_q == (wt_q - 9'd1));
  assign y_last    = (y_q == (ht_q - 9'd1));
  assign last_beat = accept && x_last && y_last;
  assign start_ok  = (state_q == ST_IDLE) && start;
  assign zero_size = (ht_out == 9'd0) || (wt_out == 9'd0);

  // ---------------------------------------------------------------------------
  // Data path: arithmetic shift then clamp to the DW_OUT signed range.
  // ---------------------------------------------------------------------------
  localparam logic signed [DW_IN-1:0] SAT_MAX =
    $signed({{(DW_IN-DW_OUT+1){1'b0}}, {(DW_OUT-1){1'b1}}});
  localparam logic signed [DW_IN-1:0] SAT_MIN =
    $signed({{(DW_IN-DW_OUT+1){1'b1}}, {(DW_OUT-1){1'b0}}});

  logic signed [DW_IN-1:0]  shifted;
  logic        [DW_OUT-1:0] sat_val;
  logic        [DW_OUT-1:0] out_val;

  always_comb begin
    shifted = $signed(in_data) >>> SHIFT;
    sat_val = shifted[DW_OUT-1:0];
    if (shifted > SAT_MAX) begin
      sat_val = {1'b0, {(DW_OUT-1){1'b1}}};
    end else if (shifted < SAT_MIN) begin
      sat_val = {1'b1, {(DW_OUT-1){1'b0}}};
    end
  end

`ifdef WRITEBACK_RELU_EN
  assign out_val = sat_val[DW_OUT-1] ? '0 : sat_val;
`else
  assign out_val = sat_val;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = zero_size ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (last_beat) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready   = 1'b0;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      ST_RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      ST_DONE: begin
        busy       = 1'b1;
        frame_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign dbg_state_o = state_q;

  // ---------------------------------------------------------------------------
  // Geometry latch and raster counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ht_q       <= '0;
      wt_q       <= '0;
      base_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      row_base_q <= '0;
    end else if (start_ok) begin
      ht_q       <= ht_out;
      wt_q       <= wt_out;
      base_q     <= base_addr;
      x_q        <= '0;
      y_q        <= '0;
      row_base_q <= '0;
    end else if (accept) begin
      if (x_last) begin
        // Row wrap happens in the same cycle: no bubble at row boundaries
        x_q        <= '0;
        y_q        <= y_q + 9'd1;
        row_base_q <= row_base_q + {{(AW-9){1'b0}}, wt_q};
      end else begin
        x_q <= x_q + 9'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registered write port; address/data hold between writes
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= accept;
      if (accept) begin
        wr_addr_q <= base_q + row_base_q + {{(AW-9){1'b0}}, x_q};
        wr_data_q <= out_val;
      end
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule

// File: tb/tb_writeback_l2.sv
`timescale 1ns/1ps

module tb_writeback_l2;

  localparam int DW_IN  = 20;
  localparam int DW_OUT = 16;
  localparam int SHIFT  = 4;
  localparam int AW     = 18;
  localparam int EW     = AW + DW_OUT;

  logic              clk;
  logic              rst;
  logic              start;
  logic [8:0]        ht_out;
  logic [8:0]        wt_out;
  logic [AW-1:0]     base_addr;
  logic              in_valid;
  logic [DW_IN-1:0]  in_data;
  logic              in_ready;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW_OUT-1:0] wr_data;
  logic              busy;
  logic              frame_done;
  logic [1:0]        dbg_state;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;

  logic [EW-1:0] exp_q[$];

  writeback_l2 #(
    .DW_IN(DW_IN), .DW_OUT(DW_OUT), .SHIFT(SHIFT), .AW(AW)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .ht_out(ht_out), .wt_out(wt_out), .base_addr(base_addr),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .frame_done(frame_done), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [DW_OUT-1:0] sat_model(input logic [DW_IN-1:0] d);
    int v;
    logic [DW_OUT-1:0] r;
    v = int'($signed(d));
    v = v >>> SHIFT;
    if (v > 32767) r = 16'h7FFF;
    else if (v < -32768) r = 16'h8000;
    else r = v[15:0];
`ifdef WRITEBACK_RELU_EN
    if (v < 0) r = 16'h0000;
`endif
    return r;
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst && wr_en) begin
      logic [EW-1:0] e;
      wr_count = wr_count + 1;
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL write_unexpected: got addr=%h data=%h, expected no write", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        if ({wr_addr, wr_data} !== e) begin
          errors = errors + 1;
          $display("FAIL write_seq: got addr=%h data=%h, expected addr=%h data=%h",
                   wr_addr, wr_data, e[EW-1:DW_OUT], e[DW_OUT-1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [8:0] ht, input logic [8:0] wt, input logic [AW-1:0] base);
    start = 1'b1;
    ht_out = ht;
    wt_out = wt;
    base_addr = base;
    tick();
    start = 1'b0;
    ht_out = $urandom_range(0, 511);
    wt_out = $urandom_range(0, 511);
    base_addr = AW'($urandom_range(0, 262143));
  endtask

  // Present one beat; returns at posedge+1 after acceptance
  task automatic send_beat(input logic [DW_IN-1:0] d, input logic [AW-1:0] ea, input logic [DW_OUT-1:0] ed);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data = d;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL beat_timeout: in_ready=%b after 20 cycles, expected 1", in_ready);
      in_valid = 1'b0;
    end else begin
      exp_q.push_back({ea, ed});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1;
    checks = checks + 1;
    if ({in_ready, wr_en, busy, frame_done} !== 4'b0000) begin
      errors = errors + 1;
      $display("FAIL reset_ctrl: got rdy/wen/busy/done=%b, expected 0000", {in_ready, wr_en, busy, frame_done});
    end
    checks = checks + 1;
    if (wr_addr !== '0 || wr_data !== '0) begin
      errors = errors + 1;
      $display("FAIL reset_data: got addr=%h data=%h, expected 0/0", wr_addr, wr_data);
    end
    checks = checks + 1;
    if (dbg_state !== 2'd0) begin
      errors = errors + 1;
      $display("FAIL reset_state: got %0d, expected 0", dbg_state);
    end
  endtask

  task automatic test_basic();
    int c0;
    c0 = wr_count;
    start_frame(9'd3, 9'd4, 18'h100);
    checks = checks + 1;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL start_latency: got in_ready=%b busy=%b, expected 1/1", in_ready, busy);
    end
    for (int k = 0; k < 12; k++) begin
      send_beat(DW_IN'(k << 4), AW'(18'h100 + k), DW_OUT'(k));
    end
    checks = checks + 1;
    if (frame_done !== 1'b1 || wr_en !== 1'b1 || wr_addr !== 18'h10B) begin
      errors = errors + 1;
      $display("FAIL basic_done_coincident: got done=%b wr_en=%b addr=%h, expected 1/1/10b",
               frame_done, wr_en, wr_addr);
    end
    tick();
    checks = checks + 1;
    if (frame_done !== 1'b0 || busy !== 1'b0 || wr_en !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL basic_idle: got done=%b busy=%b wr_en=%b, expected 0/0/0", frame_done, busy, wr_en);
    end
    checks = checks + 1;
    if (wr_addr !== 18'h10B || wr_data !== 16'd11) begin
      errors = errors + 1;
      $display("FAIL basic_hold: got addr=%h data=%h, expected 10b/000b", wr_addr, wr_data);
    end
    tick();
    checks = checks + 1;
    if (wr_count - c0 !== 12 || exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL basic_count: got %0d writes, %0d pending, expected 12/0", wr_count - c0, exp_q.size());
    end
  endtask

  task automatic test_gapped();
    int c0;
    c0 = wr_count;
    start_frame(9'd3, 9'd4, 18'h100);
    for (int k = 0; k < 12; k++) begin
      send_beat(DW_IN'(k << 4), AW'(18'h100 + k), DW_OUT'(k));
      in_data = DW_IN'($urandom_range(0, 1048575));
      tick();
    end
    tick();
    checks = checks + 1;
    if (wr_count - c0 !== 12 || exp_q.size() != 0 || busy !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL gapped_count: got %0d writes, %0d pending, busy=%b, expected 12/0/0",
               wr_count - c0, exp_q.size(), busy);
    end
  endtask

  task automatic test_saturation();
    logic [DW_IN-1:0] d;
    start_frame(9'd1, 9'd3, 18'h040);
    send_beat(20'h7FFFF, 18'h040, 16'h7FFF);
    d = -20'sh80000;
    send_beat(d, 18'h041, 16'h8000);
    d = -20'sd32;
`ifdef WRITEBACK_RELU_EN
    send_beat(d, 18'h042, 16'h0000);
`else
    send_beat(d, 18'h042, 16'hFFFE);
`endif
    tick();
    tick();
    // Random frame checked against the model
    begin
      logic [AW-1:0] b;
      b = AW'($urandom_range(0, 262143));
      start_frame(9'd2, 9'd5, b);
      for (int k = 0; k < 10; k++) begin
        d = DW_IN'($urandom_range(0, 1048575));
        send_beat(d, b + AW'(k), sat_model(d));
      end
    end
    tick();
    tick();
    checks = checks + 1;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL sat_drain: got %0d pending busy=%b, expected 0/0", exp_q.size(), busy);
    end
  endtask

  task automatic test_edges();
    int c0;
    c0 = wr_count;
    start_frame(9'd0, 9'd4, 18'h123);
    checks = checks + 1;
    if (frame_done !== 1'b1 || in_ready !== 1'b0 || wr_en !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL zero_done: got done=%b rdy=%b wr_en=%b, expected 1/0/0", frame_done, in_ready, wr_en);
    end
    tick();
    checks = checks + 1;
    if (frame_done !== 1'b0 || busy !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL zero_idle: got done=%b busy=%b, expected 0/0", frame_done, busy);
    end
    tick();
    checks = checks + 1;
    if (wr_count != c0) begin
      errors = errors + 1;
      $display("FAIL zero_nowrite: got %0d writes, expected 0", wr_count - c0);
    end
    start_frame(9'd1, 9'd4, 18'h3FFFE);
    send_beat(20'h00010, 18'h3FFFE, 16'h0001);
    send_beat(20'h00020, 18'h3FFFF, 16'h0002);
    send_beat(20'h00030, 18'h00000, 16'h0003);
    send_beat(20'h00040, 18'h00001, 16'h0004);
    tick();
    tick();
    checks = checks + 1;
    if (wr_count - c0 !== 4 || exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL wrap_count: got %0d writes %0d pending, expected 4/0", wr_count - c0, exp_q.size());
    end
  endtask

  task automatic test_start_hazard();
    start_frame(9'd2, 9'd3, 18'h500);
    send_beat(20'h00050, 18'h500, 16'h0005);
    send_beat(20'h00060, 18'h501, 16'h0006);
    start = 1'b1;
    ht_out = 9'd1;
    wt_out = 9'd1;
    base_addr = 18'h900;
    tick();
    start = 1'b0;
    checks = checks + 1;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL start_in_run: got busy=%b rdy=%b, expected 1/1", busy, in_ready);
    end
    send_beat(20'h00070, 18'h502, 16'h0007);
    send_beat(20'h00080, 18'h503, 16'h0008);
    send_beat(20'h00090, 18'h504, 16'h0009);
    start = 1'b1;
    send_beat(20'h000A0, 18'h505, 16'h000A);
    start = 1'b0;
    checks = checks + 1;
    if (frame_done !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL hazard_done: got done=%b, expected 1", frame_done);
    end
    tick();
    checks = checks + 1;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL start_on_last: got busy=%b rdy=%b, expected 0/0", busy, in_ready);
    end
    tick();
  endtask

  task automatic test_reset_mid_frame();
    int c0;
    start_frame(9'd3, 9'd4, 18'h100);
    for (int k = 0; k < 5; k++) begin
      send_beat(DW_IN'(k << 4), AW'(18'h100 + k), DW_OUT'(k));
    end
    rst = 1'b0;
    #1;
    checks = checks + 1;
    if ({in_ready, wr_en, busy, frame_done} !== 4'b0000 || wr_addr !== '0 || wr_data !== '0) begin
      errors = errors + 1;
      $display("FAIL reset_mid: got rdy/wen/busy/done=%b addr=%h data=%h, expected 0000/0/0",
               {in_ready, wr_en, busy, frame_done}, wr_addr, wr_data);
    end
    // The fifth write was cancelled by reset
    exp_q.delete();
    in_valid = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    c0 = wr_count;
    checks = checks + 1;
    if (wr_en !== 1'b0 || busy !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL reset_release: got wr_en=%b busy=%b, expected 0/0", wr_en, busy);
    end
    start_frame(9'd1, 9'd2, 18'h700);
    send_beat(20'h00110, 18'h700, 16'h0011);
    send_beat(20'h00120, 18'h701, 16'h0012);
    for (int i = 0; i < 4; i++) tick();
    checks = checks + 1;
    if (wr_count - c0 !== 2 || exp_q.size() != 0 || busy !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL post_reset_frame: got %0d writes %0d pending busy=%b, expected 2/0/0",
               wr_count - c0, exp_q.size(), busy);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b0;
    start = 1'b0;
    ht_out = '0;
    wt_out = '0;
    base_addr = '0;
    in_valid = 1'b0;
    in_data = '0;
    repeat (3) @(posedge clk);
    test_reset();
    tick();
    rst = 1'b1;
    tick();
    test_basic();
    test_gapped();
    test_saturation();
    test_edges();
    test_start_hazard();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at 200us, expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/writeback_l2.md
# writeback_l2

- Layer-2 output writer: the write-side counterpart of the layer-2 read address generator.
- Accepts one computed result per handshake from the convolution/pooling datapath and rescales it (arithmetic shift plus signed saturation).
- Writes the result to the output feature-map RAM in raster order at base_addr + y*wt_out + x.
- Signals frame completion so the layer controller can start the next layer.

## Interface
Parameters:
- DW_IN, 20, signed accumulator width of incoming results
- DW_OUT, 16, signed width written to RAM
- SHIFT, 4, arithmetic right shift applied before saturation
- AW, 18, RAM address width

Ports:
- clk  input  1  clock; everything samples on the rising edge
- rst  input  1  reset, asynchronous and active-low
- start  input  1  one-cycle pulse; latches dimensions and base, begins a frame
- ht_out  input  9  output map height, sampled at start
- wt_out  input  9  output map width, sampled at start
- base_addr  input  AW  first RAM address of the map, sampled at start
- in_valid  input  1  result beat valid
- in_data  input  DW_IN  signed result
- in_ready  output  1  writer can accept a beat
- wr_en  output  1  RAM write strobe
- wr_addr  output  AW  RAM write address
- wr_data  output  DW_OUT  RAM write data
- busy  output  1  frame in progress
- frame_done  output  1  one-cycle pulse when the frame is complete

## Operation
- Three states: IDLE, RUN, DONE.
- IDLE:
  - start latches ht_out, wt_out and base_addr, and clears x, y and row_base.
  - If ht_out==0 or wt_out==0, go to DONE; otherwise go to RUN.
- RUN:
  - in_ready=1.
  - A beat is accepted when in_valid && in_ready at the clock edge.
  - Each accepted beat is written to base + row_base + x.
  - x increments. When x==wt-1, x goes to 0, y increments and row_base += wt.
  - The beat accepted with x==wt-1 and y==ht-1 is the last beat; the state moves to DONE.
- DONE: frame_done=1 for exactly one cycle, then IDLE.
- No multiplier: the row offset is kept in the accumulated row_base (AW bits).
- Address arithmetic is modulo 2^AW; wrap-around is silent.
- Data path:
  - s = in_data >>> SHIFT (arithmetic).
  - If s > 2^(DW_OUT-1)-1, wr_data = 0x7FFF.
  - If s < -2^(DW_OUT-1), wr_data = 0x8000.
  - Otherwise wr_data = s[DW_OUT-1:0].
- busy=1 in RUN and DONE.
- in_ready=0 in IDLE and DONE. in_valid while in_ready=0 is ignored; the upstream holds the beat.
- start while busy is ignored, including start coincident with the last beat.
- Input dimension and base changes during a frame have no effect.
- Reset at any time returns to IDLE immediately and discards any partial frame. No write is issued after reset.

## Timing
- Reset values: in_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, frame_done=0.
- start to in_ready=1: 1 cycle.
- Write latency: wr_en, wr_addr and wr_data are registered.
  - They are valid in the cycle after acceptance.
  - wr_en is high for exactly one cycle per accepted beat.
- Throughput: 1 beat/cycle sustained, with no bubble at row boundaries.
- Last beat accepted at edge N:
  - last wr_en in cycle N+1, coincident with frame_done=1 (state DONE).
  - IDLE from N+2; a new start is accepted from cycle N+2.
- Zero-size frame: frame_done pulses in the cycle after start; wr_en is never asserted.
- wr_addr and wr_data hold their last values when wr_en=0.

## Configuration
- WRITEBACK_RELU_EN:
  - When defined, a ReLU is applied after saturation: negative results are written as 0.
  - When undefined, signed saturated values are written unchanged.
- Latency and handshake are identical in both builds.

## Test plan
- Basic raster: reset, start with ht=3, wt=4, base=0x100, then 12 back-to-back beats with data k<<4.
  - Required: wr_addr 0x100..0x10B in order, wr_data k, 12 wr_en pulses.
  - Required: frame_done coincident with the last write.
- Gapped valid: same frame with in_valid toggling every other cycle.
  - Required: identical address/data sequence, no duplicate or missing writes.
- Saturation, SHIFT=4:
  - in_data=0x7FFFF writes 0x7FFF.
  - in_data=-0x80000 writes 0x8000.
  - in_data=-32 writes 0xFFFE without RELU, 0x0000 with WRITEBACK_RELU_EN.
- Edges:
  - ht=0 gives a frame_done pulse 1 cycle after start and no wr_en.
  - base=0x3FFFE, wt=4, ht=1 writes addresses 0x3FFFE, 0x3FFFF, 0x00000, 0x00001.
- Control hazards:
  - start during RUN is ignored.
  - Reset asserted after 5 of 12 beats: all outputs return to reset values immediately.
  - A following start with ht=1, wt=2 writes base+0 and base+1 only.
